// File: rtl/aes_sub_bytes_serial.sv
// Serialized AES SubBytes: SBOX_LANES combinational S-boxes walk the 16-byte state
// in PASSES cycles, then hold the result until the downstream handshake completes.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = x_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  assign y = affine(gf_inv(a));

endmodule

module aes_sub_bytes_serial #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int PASSES = 16 / SBOX_LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PASSES - 1);

  generate
    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
          SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
      $error("aes_sub_bytes_serial: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [127:0]       buf_r;
  logic [127:0]       buf_sub_s;
  logic               load_s;
  logic               pass_s;
  logic [7:0]         sb_in_s  [SBOX_LANES];
  logic [7:0]         sb_out_s [SBOX_LANES];

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    aes_sbox u_sbox (.a(sb_in_s[g]), .y(sb_out_s[g]));
  end

  // pick the byte group addressed by the pass counter
  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++) begin
      sb_in_s[l] = buf_r[127 - 8 * (int'(cnt_r) * SBOX_LANES + l) -: 8];
    end
  end

  // merge substituted group back into the buffer image
  always_comb begin
    buf_sub_s = buf_r;
    for (int l = 0; l < SBOX_LANES; l++) begin
      buf_sub_s[127 - 8 * (int'(cnt_r) * SBOX_LANES + l) -: 8] = sb_out_s[l];
    end
  end

  // next-state and datapath control; clr overrides every handshake
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    pass_s  = 1'b0;
    if (clr) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            load_s  = 1'b1;
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          pass_s = 1'b1;
          if (cnt_r == LAST) state_s = DONE;
          else               state_s = RUN;
        end
        DONE: begin
          if (out_ready) state_s = IDLE;
          else           state_s = DONE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // state buffer and pass counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r <= 128'h0;
      cnt_r <= '0;
    end else if (clr) begin
      buf_r <= 128'h0;
      cnt_r <= '0;
    end else if (load_s) begin
      buf_r <= in_state;
      cnt_r <= '0;
    end else if (pass_s) begin
      buf_r <= buf_sub_s;
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + CNT_W'(1);
    end else begin
      buf_r <= buf_r;
      cnt_r <= cnt_r;
    end
  end

  // rst_n gates in_ready so nothing looks acceptable while held in reset
  assign in_ready  = (state_r == IDLE) && rst_n;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign out_state = buf_r & {128{out_valid}};

endmodule
